// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter: write handshake for the TX FIFO
// plus the status flags the APB register block reads back.
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [PAYLOAD_BITS-1:0] uart_tx_data;
  logic                    uart_tx_valid;
  logic                    uart_tx_ready;
  logic                    uart_tx_busy;
  logic                    uart_tx_done;
  logic [LW-1:0]           uart_tx_level;

  // Producer (APB side): pushes words, observes status.
  modport master (
    output uart_tx_data, uart_tx_valid,
    input  uart_tx_ready, uart_tx_busy, uart_tx_done, uart_tx_level
  );

  // Transmitter: accepts words, reports status.
  modport slave (
    input  uart_tx_data, uart_tx_valid,
    output uart_tx_ready, uart_tx_busy, uart_tx_done, uart_tx_level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small synchronous TX FIFO.
// Frame: idle high, start bit 0, LSB-first payload, optional parity,
// STOP_BITS stop bits. Bit timing uses the same integer formula as the
// UART receiver so both ends agree on CYCLES_PER_BIT.
module uart_tx_fifo #(
  parameter int BIT_RATE     = 115200,
  parameter int CLK_HZ       = 10_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  tx_if,
  output logic           uart_txd
);

  localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P          = 1_000_000_000 / CLK_HZ;
  localparam int CYCLES_PER_BIT = BIT_P / CLK_P;
  localparam int AW             = $clog2(FIFO_DEPTH);
  localparam int LW             = AW + 1;
  localparam int CW             = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BW             = $clog2(PAYLOAD_BITS + STOP_BITS);

  localparam logic [CW-1:0] CYC_LAST   = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          ODD_PARITY = (PARITY == 1);
  localparam logic          HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [LW-1:0]           count;
  logic                    full, empty, push, pop;
  logic [PAYLOAD_BITS-1:0] head;

  // ready derives only from the registered count, so pop never reaches it.
  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = tx_if.uart_tx_valid && !full;
  assign head  = mem[rd_ptr];

  // Storage array write port.
  // NOTE: the data array has no reset; pointers and count define what is valid,
  // so a reset flushes the FIFO without clearing every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_if.uart_tx_data;
  end

  // Pointers wrap naturally at FIFO_DEPTH (power of two); count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    par_q, par_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic                    txd_d, done_q, done_d;
  logic                    bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  // Next-state, datapath and pop decode; txd is derived from the next state so
  // the pin register changes on the same edge as the state.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ ODD_PARITY;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d  = '0;
            done_d = 1'b1;
            if (!empty) begin
              // Back-to-back frame: no idle gap between stop and start.
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ ODD_PARITY;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  // FSM state, counters, shift register and the registered TX pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      par_q    <= 1'b0;
      cyc_q    <= '0;
      bit_q    <= '0;
      uart_txd <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      uart_txd <= txd_d;
      done_q   <= done_d;
    end
  end

  assign tx_if.uart_tx_ready = !full;
  assign tx_if.uart_tx_busy  = (state_q != S_IDLE) || !empty;
  assign tx_if.uart_tx_done  = done_q;
  assign tx_if.uart_tx_level = count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo. Four instances cover the frame
// formats: 10 cycles/bit without parity, even and odd parity with two stop
// bits, and the default 86 cycles/bit looped into a small serial receiver.
module tb_uart_tx_fifo;

  logic clk;
  logic reset;
  logic txd_a, txd_b, txd_c, txd_d;

  uart_tx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) if_b ();
  uart_tx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) if_c ();
  uart_tx_fifo_if #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4)) if_d ();

  uart_tx_fifo #(.BIT_RATE(1_000_000), .CLK_HZ(10_000_000), .PAYLOAD_BITS(8),
                 .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4))
    u_a (.clk(clk), .reset(reset), .tx_if(if_a), .uart_txd(txd_a));

  uart_tx_fifo #(.BIT_RATE(1_000_000), .CLK_HZ(10_000_000), .PAYLOAD_BITS(8),
                 .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4))
    u_b (.clk(clk), .reset(reset), .tx_if(if_b), .uart_txd(txd_b));

  uart_tx_fifo #(.BIT_RATE(1_000_000), .CLK_HZ(10_000_000), .PAYLOAD_BITS(8),
                 .STOP_BITS(2), .PARITY(1), .FIFO_DEPTH(4))
    u_c (.clk(clk), .reset(reset), .tx_if(if_c), .uart_txd(txd_c));

  uart_tx_fifo #(.BIT_RATE(115200), .CLK_HZ(10_000_000), .PAYLOAD_BITS(8),
                 .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4))
    u_d (.clk(clk), .reset(reset), .tx_if(if_d), .uart_txd(txd_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux: sel picks which instance the frame checker watches.
  int         sel;
  logic       mon_txd, mon_done, mon_busy, mon_ready;
  logic [2:0] mon_level;

  always_comb begin
    mon_txd   = txd_a;
    mon_done  = if_a.uart_tx_done;
    mon_busy  = if_a.uart_tx_busy;
    mon_ready = if_a.uart_tx_ready;
    mon_level = if_a.uart_tx_level;
    case (sel)
      1: begin
        mon_txd = txd_b; mon_done = if_b.uart_tx_done; mon_busy = if_b.uart_tx_busy;
        mon_ready = if_b.uart_tx_ready; mon_level = if_b.uart_tx_level;
      end
      2: begin
        mon_txd = txd_c; mon_done = if_c.uart_tx_done; mon_busy = if_c.uart_tx_busy;
        mon_ready = if_c.uart_tx_ready; mon_level = if_c.uart_tx_level;
      end
      3: begin
        mon_txd = txd_d; mon_done = if_d.uart_tx_done; mon_busy = if_d.uart_tx_busy;
        mon_ready = if_d.uart_tx_ready; mon_level = if_d.uart_tx_level;
      end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    case (which)
      0: begin if_a.uart_tx_valid = v; if_a.uart_tx_data = d; end
      1: begin if_b.uart_tx_valid = v; if_b.uart_tx_data = d; end
      2: begin if_c.uart_tx_valid = v; if_c.uart_tx_data = d; end
      default: begin if_d.uart_tx_valid = v; if_d.uart_tx_data = d; end
    endcase
  endtask

  // Called at the negedge between the acceptance edge and the start-bit edge.
  // bits[i] is the i-th bit on the wire; each must hold for exactly cpb samples.
  // done0 is the expected done level at the first sample (end of previous frame).
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int cpb, input logic done0);
    int good;
    int stray;
    stray = 0;
    for (int b = 0; b < nbits; b++) begin
      good = 0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (mon_txd === bits[b]) good++;
        if (b == 0 && c == 0) check({tag, ".done_prev"}, 32'(mon_done), 32'(done0));
        else if (mon_done !== 1'b0) stray++;
      end
      check($sformatf("%s.bit%0d", tag, b), good, cpb);
    end
    check({tag, ".stray_done"}, stray, 0);
  endtask

  // Serial receiver model for the 86 cycles/bit loopback: mid-bit sampling.
  logic       rx_en;
  logic [8:0] rx_q [$];

  initial begin
    forever begin : rx_loop
      logic [7:0] b;
      logic       ok;
      @(negedge clk);
      if (rx_en && txd_d === 1'b0) begin
        repeat (42) @(negedge clk);
        ok = (txd_d === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (86) @(negedge clk);
          b[i] = txd_d;
        end
        repeat (86) @(negedge clk);
        ok = ok && (txd_d === 1'b1);
        rx_q.push_back({ok, b});
      end
    end
  end

  logic [15:0] frames3 [5];
  logic [7:0]  words6  [4];

  initial begin
    int good;
    int dn;

    reset = 1'b1;
    sel   = 0;
    rx_en = 1'b0;
    for (int w = 0; w < 4; w++) drive(w, 1'b0, 8'h00);

    // Reset state held through and after reset.
    good = 0;
    repeat (3) begin
      @(negedge clk);
      if (mon_txd === 1'b1 && mon_ready === 1'b1 && mon_busy === 1'b0 &&
          mon_level === 3'd0 && mon_done === 1'b0) good++;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mon_txd === 1'b1 && mon_ready === 1'b1 && mon_busy === 1'b0 &&
          mon_level === 3'd0 && mon_done === 1'b0) good++;
    end
    check("t1.reset_idle", good, 8);

    // Single frame 0xA5, 10 cycles/bit: 0,1,0,1,0,0,1,0,1,1.
    sel = 0;
    drive(0, 1'b1, 8'hA5);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("t2.txd_before_start", 32'(mon_txd), 1);
    check("t2.busy_queued", 32'(mon_busy), 1);
    check_frame("t2", 16'b0000_0011_0100_1010, 10, 10, 1'b0);
    @(negedge clk);
    check("t2.done", 32'(mon_done), 1);
    check("t2.txd_idle", 32'(mon_txd), 1);
    @(negedge clk);
    check("t2.done_once", 32'(mon_done), 0);
    check("t2.busy_end", 32'(mon_busy), 0);

    // Six consecutive writes: 0x06 hits a full FIFO and is dropped.
    frames3[0] = 16'h0202; frames3[1] = 16'h0204; frames3[2] = 16'h0206;
    frames3[3] = 16'h0208; frames3[4] = 16'h020A;
    drive(0, 1'b1, 8'h01);
    fork
      begin
        for (int i = 2; i <= 6; i++) begin
          @(negedge clk);
          if (i == 6) begin
            check("t3.level_full", 32'(mon_level), 4);
            check("t3.ready_full", 32'(mon_ready), 0);
          end
          drive(0, 1'b1, 8'(i));
        end
        @(negedge clk);
        check("t3.level_after_drop", 32'(mon_level), 4);
        drive(0, 1'b0, 8'h00);
      end
      begin
        @(negedge clk);
        check("t3.txd_before_start", 32'(mon_txd), 1);
        for (int f = 0; f < 5; f++)
          check_frame($sformatf("t3.f%0d", f), frames3[f], 10, 10, (f != 0));
      end
    join
    @(negedge clk);
    check("t3.done_last", 32'(mon_done), 1);
    @(negedge clk);
    check("t3.busy_end", 32'(mon_busy), 0);
    check("t3.level_end", 32'(mon_level), 0);

    // Even parity, 2 stop bits: 0x07 -> parity 1, 120-cycle frame.
    sel = 1;
    drive(1, 1'b1, 8'h07);
    @(negedge clk);
    drive(1, 1'b0, 8'h00);
    check("t4e.txd_before_start", 32'(mon_txd), 1);
    check_frame("t4e", 16'b0000_1110_0000_1110, 12, 10, 1'b0);
    @(negedge clk);
    check("t4e.done", 32'(mon_done), 1);
    @(negedge clk);
    check("t4e.busy_end", 32'(mon_busy), 0);

    // Odd parity, 2 stop bits: 0x07 -> parity 0.
    sel = 2;
    drive(2, 1'b1, 8'h07);
    @(negedge clk);
    drive(2, 1'b0, 8'h00);
    check_frame("t4o", 16'b0000_1100_0000_1110, 12, 10, 1'b0);
    @(negedge clk);
    check("t4o.done", 32'(mon_done), 1);
    @(negedge clk);
    check("t4o.busy_end", 32'(mon_busy), 0);

    // Asynchronous reset in data bit 3 of 0x3C with two words queued.
    sel = 0;
    drive(0, 1'b1, 8'h3C);
    @(negedge clk);
    drive(0, 1'b1, 8'h11);
    @(negedge clk);
    drive(0, 1'b1, 8'h22);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    repeat (44) @(negedge clk);
    check("t5.level_before", 32'(mon_level), 2);
    check("t5.txd_bit3", 32'(mon_txd), 1);
    reset = 1'b1;
    #1;
    check("t5.txd_async", 32'(mon_txd), 1);
    check("t5.level_async", 32'(mon_level), 0);
    check("t5.busy_async", 32'(mon_busy), 0);
    check("t5.ready_async", 32'(mon_ready), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 8'h5A);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check_frame("t5.post", 16'h02B4, 10, 10, 1'b0);
    @(negedge clk);
    check("t5.done", 32'(mon_done), 1);
    @(negedge clk);
    check("t5.busy_end", 32'(mon_busy), 0);

    // Default rate (86 cycles/bit) looped into the receiver model.
    sel = 3;
    words6[0] = 8'h00; words6[1] = 8'hFF; words6[2] = 8'h55; words6[3] = 8'hAA;
    rx_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(3, 1'b1, words6[i]);
      @(negedge clk);
    end
    drive(3, 1'b0, 8'h00);
    dn = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (mon_done === 1'b1) dn++;
      if (rx_q.size() == 4 && mon_busy === 1'b0) break;
    end
    check("t6.rx_count", rx_q.size(), 4);
    check("t6.done_count", dn, 4);
    check("t6.busy_end", 32'(mon_busy), 0);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) begin
        check($sformatf("t6.rx%0d.data", i), 32'(rx_q[i][7:0]), 32'(words6[i]));
        check($sformatf("t6.rx%0d.framing", i), 32'(rx_q[i][8]), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
